ivalu_issue_queue: RTL and testbench

- Age-ordered issue queue and scheduler in front of the vector integer ALU (ivalu).
- Buffers renamed vector-integer micro-ops from dispatch and tracks source-operand readiness by physical tag using writeback wakeup broadcasts.
- Each cycle it selects the oldest fully-ready entry and presents it, registered, to the register-read/ivalu stage.
- ivalu has no backpressure, so this block is its only sequencer.

---
 rtl/ivalu_pkg.sv | 29 ++
 rtl/iq_oldest_select.sv | 24 ++
 rtl/ivalu_issue_queue.sv | 149 ++++++++++++++
 tb/tb_ivalu_issue_queue.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ivalu_pkg.sv
// Shared types and constants for the vector-integer ALU issue path.
// Entry layout and opcode unit-select encodings used by the issue queue.
package ivalu_pkg;

    localparam int unsigned TAG_W = 6;
    localparam int unsigned OP_W  = 7;
    localparam int unsigned ROB_W = 5;

    localparam logic [1:0] OP_UNIT_ADD  = 2'b00;
    localparam logic [1:0] OP_UNIT_CMP  = 2'b01;
    localparam logic [1:0] OP_UNIT_MISC = 2'b10;
    localparam logic [1:0] OP_UNIT_SHF  = 2'b11;

    typedef struct packed {
        logic             valid;
        logic [OP_W-1:0]  op;
        logic [ROB_W-1:0] rob;
        logic [TAG_W-1:0] dest;
        logic [TAG_W-1:0] rs1;
        logic             rs1_rdy;
        logic [TAG_W-1:0] rs2;
        logic             rs2_rdy;
    } iq_entry_t;

    function automatic logic [1:0] op_unit(input logic [OP_W-1:0] op);
        return op[5:4];
    endfunction

endpackage

// File: rtl/iq_oldest_select.sv
// Priority encoder picking the lowest-index (oldest) asserted request.
module iq_oldest_select #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0]         req,
    output logic                 found,
    output logic [$clog2(N)-1:0] idx
);

    localparam int unsigned IDX_W = $clog2(N);

    // Scan from the top so the lowest set bit wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/ivalu_issue_queue.sv
// Collapsing, age-ordered issue queue for the vector integer ALU.
// Tracks operand readiness via wakeup broadcasts and issues the oldest ready entry.
module ivalu_issue_queue #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned WAKE_PORTS = 2,
    parameter int unsigned TAG_W      = ivalu_pkg::TAG_W
) (
    input  logic                        core_clock_i,
    input  logic                        core_reset_ni,
    input  logic                        flush_i,
    input  logic                        enq_valid_i,
    output logic                        enq_ready_o,
    input  logic [6:0]                  enq_op_i,
    input  logic [4:0]                  enq_rob_i,
    input  logic [TAG_W-1:0]            enq_dest_i,
    input  logic [TAG_W-1:0]            enq_rs1_i,
    input  logic [TAG_W-1:0]            enq_rs2_i,
    input  logic                        enq_rs1_rdy_i,
    input  logic                        enq_rs2_rdy_i,
    input  logic [WAKE_PORTS-1:0]       wake_valid_i,
    input  logic [WAKE_PORTS*TAG_W-1:0] wake_tag_i,
    input  logic                        iss_stall_i,
    output logic                        iss_valid_o,
    output logic [6:0]                  iss_op_o,
    output logic [4:0]                  iss_rob_o,
    output logic [TAG_W-1:0]            iss_dest_o,
    output logic [TAG_W-1:0]            iss_rs1_o,
    output logic [TAG_W-1:0]            iss_rs2_o,
    output logic [$clog2(DEPTH+1)-1:0]  count_o
);

    import ivalu_pkg::*;

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    iq_entry_t        entries_q [DEPTH];
    iq_entry_t        entries_d [DEPTH];
    iq_entry_t        ext       [DEPTH+1];
    iq_entry_t        enq_entry;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] wr_idx;
    logic [DEPTH-1:0] ready_vec;
    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic             do_issue;
    logic             enq_accept;

    function automatic logic is_woken(input logic [TAG_W-1:0]            tag,
                                      input logic [WAKE_PORTS-1:0]       vld,
                                      input logic [WAKE_PORTS*TAG_W-1:0] tags);
        logic hit;
        hit = 1'b0;
        for (int p = 0; p < WAKE_PORTS; p++) begin
            if (vld[p] && (tags[p*TAG_W +: TAG_W] == tag)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ready_vec[i] = entries_q[i].valid & entries_q[i].rs1_rdy & entries_q[i].rs2_rdy;
        end
    end

    iq_oldest_select #(
        .N(DEPTH)
    ) u_select (
        .req  (ready_vec),
        .found(sel_found),
        .idx  (sel_idx)
    );

    // Enqueue space comes from the registered count only, never from a same-cycle issue.
    assign enq_ready_o = (count_q < CNT_W'(DEPTH));
    assign do_issue    = sel_found & ~iss_stall_i & ~flush_i;
    assign enq_accept  = enq_valid_i & enq_ready_o & ~flush_i;
    assign wr_idx      = count_q - CNT_W'(do_issue);
    assign count_d     = flush_i ? '0 : count_q + CNT_W'(enq_accept) - CNT_W'(do_issue);
    assign count_o     = count_q;

    always_comb begin
        enq_entry         = '0;
        enq_entry.valid   = 1'b1;
        enq_entry.op      = enq_op_i;
        enq_entry.rob     = enq_rob_i;
        enq_entry.dest    = enq_dest_i;
        enq_entry.rs1     = enq_rs1_i;
        enq_entry.rs2     = enq_rs2_i;
        enq_entry.rs1_rdy = (enq_rs1_i == '0) | enq_rs1_rdy_i
                          | is_woken(enq_rs1_i, wake_valid_i, wake_tag_i);
        enq_entry.rs2_rdy = (enq_rs2_i == '0) | enq_rs2_rdy_i
                          | is_woken(enq_rs2_i, wake_valid_i, wake_tag_i);
    end

    // Collapse above the issued slot, then apply wakeups, then drop in the new entry.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ext[i] = entries_q[i];
        end
        ext[DEPTH] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entries_d[i] = (do_issue && (IDX_W'(i) >= sel_idx)) ? ext[i+1] : ext[i];
            if (entries_d[i].valid) begin
                if (is_woken(entries_d[i].rs1, wake_valid_i, wake_tag_i)) begin
                    entries_d[i].rs1_rdy = 1'b1;
                end
                if (is_woken(entries_d[i].rs2, wake_valid_i, wake_tag_i)) begin
                    entries_d[i].rs2_rdy = 1'b1;
                end
            end
            if (enq_accept && (wr_idx == CNT_W'(i))) begin
                entries_d[i] = enq_entry;
            end
            if (flush_i) begin
                entries_d[i].valid = 1'b0;
            end
        end
    end

    always_ff @(posedge core_clock_i or negedge core_reset_ni) begin
        if (!core_reset_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            count_q     <= '0;
            iss_valid_o <= 1'b0;
            iss_op_o    <= '0;
            iss_rob_o   <= '0;
            iss_dest_o  <= '0;
            iss_rs1_o   <= '0;
            iss_rs2_o   <= '0;
        end else begin
            entries_q   <= entries_d;
            count_q     <= count_d;
            iss_valid_o <= do_issue;
            if (do_issue) begin
                iss_op_o   <= entries_q[sel_idx].op;
                iss_rob_o  <= entries_q[sel_idx].rob;
                iss_dest_o <= entries_q[sel_idx].dest;
                iss_rs1_o  <= entries_q[sel_idx].rs1;
                iss_rs2_o  <= entries_q[sel_idx].rs2;
            end
        end
    end

endmodule

// File: tb/tb_ivalu_issue_queue.sv
// Directed bench for ivalu_issue_queue: latency, wakeup, full, bypass, stall, flush, reset.
module tb_ivalu_issue_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        enq_valid = 1'b0;
    logic        enq_ready;
    logic [6:0]  enq_op = '0;
    logic [4:0]  enq_rob = '0;
    logic [5:0]  enq_dest = '0, enq_rs1 = '0, enq_rs2 = '0;
    logic        enq_rs1_rdy = 1'b0, enq_rs2_rdy = 1'b0;
    logic [1:0]  wake_valid = '0;
    logic [11:0] wake_tag = '0;
    logic        iss_stall = 1'b0;
    logic        iss_valid;
    logic [6:0]  iss_op;
    logic [4:0]  iss_rob;
    logic [5:0]  iss_dest, iss_rs1, iss_rs2;
    logic [3:0]  count;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ivalu_issue_queue dut (
        .core_clock_i (clk),
        .core_reset_ni(rst_n),
        .flush_i      (flush),
        .enq_valid_i  (enq_valid),
        .enq_ready_o  (enq_ready),
        .enq_op_i     (enq_op),
        .enq_rob_i    (enq_rob),
        .enq_dest_i   (enq_dest),
        .enq_rs1_i    (enq_rs1),
        .enq_rs2_i    (enq_rs2),
        .enq_rs1_rdy_i(enq_rs1_rdy),
        .enq_rs2_rdy_i(enq_rs2_rdy),
        .wake_valid_i (wake_valid),
        .wake_tag_i   (wake_tag),
        .iss_stall_i  (iss_stall),
        .iss_valid_o  (iss_valid),
        .iss_op_o     (iss_op),
        .iss_rob_o    (iss_rob),
        .iss_dest_o   (iss_dest),
        .iss_rs1_o    (iss_rs1),
        .iss_rs2_o    (iss_rs2),
        .count_o      (count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_enq(input logic [6:0] op, input logic [4:0] rob, input logic [5:0] dest,
                             input logic [5:0] rs1, input logic r1,
                             input logic [5:0] rs2, input logic r2);
        enq_valid   = 1'b1;
        enq_op      = op;
        enq_rob     = rob;
        enq_dest    = dest;
        enq_rs1     = rs1;
        enq_rs1_rdy = r1;
        enq_rs2     = rs2;
        enq_rs2_rdy = r2;
    endtask

    task automatic idle_enq();
        enq_valid = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", count); end
        vectors++; if (iss_valid !== 1'b0) begin miscompares++; $display("FAIL reset_iss_valid: got %b want 0", iss_valid); end
        vectors++; if (iss_rob !== 5'd0) begin miscompares++; $display("FAIL reset_iss_rob: got %0d want 0", iss_rob); end
        vectors++; if (iss_dest !== 6'd0) begin miscompares++; $display("FAIL reset_iss_dest: got %0d want 0", iss_dest); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        vectors++; if (enq_ready !== 1'b1) begin miscompares++; $display("FAIL reset_enq_ready: got %b want 1", enq_ready); end
        vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL reset_count_after: got %0d want 0", count); end
    endtask

    task automatic test_basic();
        drive_enq(7'h01, 5'd3, 6'd5, 6'd0, 1'b0, 6'd0, 1'b0);
        tick();
        idle_enq();
        vectors++; if (count !== 4'd1) begin miscompares++; $display("FAIL basic_count1: got %0d want 1", count); end
        vectors++; if (iss_valid !== 1'b0) begin miscompares++; $display("FAIL basic_early: got %b want 0", iss_valid); end
        tick();
        vectors++; if (iss_valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid: got %b want 1", iss_valid); end
        vectors++; if (iss_dest !== 6'd5) begin miscompares++; $display("FAIL basic_dest: got %0d want 5", iss_dest); end
        vectors++; if (iss_rob !== 5'd3) begin miscompares++; $display("FAIL basic_rob: got %0d want 3", iss_rob); end
        vectors++; if (iss_op !== 7'h01) begin miscompares++; $display("FAIL basic_op: got %0h want 1", iss_op); end
        vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL basic_count0: got %0d want 0", count); end
        tick();
        vectors++; if (iss_valid !== 1'b0) begin miscompares++; $display("FAIL basic_drop: got %b want 0", iss_valid); end
        vectors++; if (iss_rob !== 5'd3) begin miscompares++; $display("FAIL basic_hold_rob: got %0d want 3", iss_rob); end
    endtask

    task automatic test_wakeup();
        wake_tag   = {6'd9, 6'd9};
        wake_valid = 2'b00;
        drive_enq(7'h11, 5'd1, 6'd7, 6'd9, 1'b0, 6'd0, 1'b1);
        tick();
        drive_enq(7'h12, 5'd2, 6'd8, 6'd0, 1'b0, 6'd0, 1'b0);
        tick();
        idle_enq();
        vectors++; if (count !== 4'd2) begin miscompares++; $display("FAIL wake_count2: got %0d want 2", count); end
        vectors++; if (iss_valid !== 1'b0) begin miscompares++; $display("FAIL wake_none: got %b want 0", iss_valid); end
        tick();
        vectors++; if (iss_valid !== 1'b1) begin miscompares++; $display("FAIL wake_b_valid: got %b want 1", iss_valid); end
        vectors++; if (iss_rob !== 5'd2) begin miscompares++; $display("FAIL wake_b_first: got %0d want 2", iss_rob); end
        wake_valid = 2'b10;
        tick();
        wake_valid = 2'b00;
        vectors++; if (iss_valid !== 1'b0) begin miscompares++; $display("FAIL wake_a_early: got %b want 0", iss_valid); end
        tick();
        vectors++; if (iss_valid !== 1'b1) begin miscompares++; $display("FAIL wake_a_valid: got %b want 1", iss_valid); end
        vectors++; if (iss_rob !== 5'd1) begin miscompares++; $display("FAIL wake_a_rob: got %0d want 1", iss_rob); end
        vectors++; if (iss_dest !== 6'd7) begin miscompares++; $display("FAIL wake_a_dest: got %0d want 7", iss_dest); end
        tick();
        vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL wake_count0: got %0d want 0", count); end
    endtask

    task automatic test_full();
        wake_tag   = {6'd0, 6'd12};
        wake_valid = 2'b00;
        for (int i = 0; i < 8; i++) begin
            drive_enq(7'h20, 5'(10 + i), 6'(10 + i), 6'd12, 1'b0, 6'd0, 1'b1);
            tick();
        end
        vectors++; if (count !== 4'd8) begin miscompares++; $display("FAIL full_count: got %0d want 8", count); end
        vectors++; if (enq_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready: got %b want 0", enq_ready); end
        drive_enq(7'h21, 5'd31, 6'd31, 6'd0, 1'b1, 6'd0, 1'b1);
        tick();
        idle_enq();
        vectors++; if (count !== 4'd8) begin miscompares++; $display("FAIL full_reject: got %0d want 8", count); end
        wake_valid = 2'b01;
        tick();
        wake_valid = 2'b00;
        vectors++; if (iss_valid !== 1'b0) begin miscompares++; $display("FAIL full_early: got %b want 0", iss_valid); end
        for (int k = 0; k < 8; k++) begin
            tick();
            vectors++;
            if (iss_valid !== 1'b1) begin miscompares++; $display("FAIL full_valid[%0d]: got %b want 1", k, iss_valid); end
            vectors++;
            if (iss_rob !== 5'(10 + k)) begin miscompares++; $display("FAIL full_order[%0d]: got %0d want %0d", k, iss_rob, 10 + k); end
            if (k == 0) begin
                vectors++; if (count !== 4'd7) begin miscompares++; $display("FAIL full_count7: got %0d want 7", count); end
                vectors++; if (enq_ready !== 1'b1) begin miscompares++; $display("FAIL full_resume: got %b want 1", enq_ready); end
            end
        end
        tick();
        vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL full_drain: got %0d want 0", count); end
        vectors++; if (iss_valid !== 1'b0) begin miscompares++; $display("FAIL full_after: got %b want 0", iss_valid); end
    endtask

    task automatic test_bypass();
        wake_tag   = {6'd0, 6'd20};
        wake_valid = 2'b01;
        drive_enq(7'h05, 5'd4, 6'd21, 6'd0, 1'b0, 6'd20, 1'b0);
        tick();
        idle_enq();
        wake_valid = 2'b00;
        vectors++; if (count !== 4'd1) begin miscompares++; $display("FAIL byp_count: got %0d want 1", count); end
        vectors++; if (iss_valid !== 1'b0) begin miscompares++; $display("FAIL byp_early: got %b want 0", iss_valid); end
        tick();
        vectors++; if (iss_valid !== 1'b1) begin miscompares++; $display("FAIL byp_valid: got %b want 1", iss_valid); end
        vectors++; if (iss_rob !== 5'd4) begin miscompares++; $display("FAIL byp_rob: got %0d want 4", iss_rob); end
        vectors++; if (iss_rs2 !== 6'd20) begin miscompares++; $display("FAIL byp_rs2: got %0d want 20", iss_rs2); end
        tick();
        vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL byp_count0: got %0d want 0", count); end
    endtask

    task automatic test_stall();
        iss_stall = 1'b1;
        drive_enq(7'h30, 5'd6, 6'd6, 6'd0, 1'b0, 6'd0, 1'b0);
        tick();
        drive_enq(7'h31, 5'd7, 6'd7, 6'd0, 1'b0, 6'd0, 1'b0);
        tick();
        idle_enq();
        for (int c = 0; c < 3; c++) begin
            tick();
            vectors++; if (iss_valid !== 1'b0) begin miscompares++; $display("FAIL stall_valid[%0d]: got %b want 0", c, iss_valid); end
            vectors++; if (count !== 4'd2) begin miscompares++; $display("FAIL stall_count[%0d]: got %0d want 2", c, count); end
        end
        iss_stall = 1'b0;
        tick();
        vectors++; if (iss_rob !== 5'd6 || iss_valid !== 1'b1) begin miscompares++; $display("FAIL stall_first: got v=%b rob=%0d want v=1 rob=6", iss_valid, iss_rob); end
        tick();
        vectors++; if (iss_rob !== 5'd7 || iss_valid !== 1'b1) begin miscompares++; $display("FAIL stall_second: got v=%b rob=%0d want v=1 rob=7", iss_valid, iss_rob); end
        tick();
        vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL stall_count0: got %0d want 0", count); end
    endtask

    task automatic test_flush();
        wake_valid = 2'b00;
        for (int i = 0; i < 4; i++) begin
            drive_enq(7'h40, 5'(20 + i), 6'd1, 6'd30, 1'b0, 6'd0, 1'b1);
            tick();
        end
        idle_enq();
        vectors++; if (count !== 4'd4) begin miscompares++; $display("FAIL flush_pre: got %0d want 4", count); end
        drive_enq(7'h41, 5'd25, 6'd2, 6'd0, 1'b0, 6'd0, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle_enq();
        vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL flush_count: got %0d want 0", count); end
        vectors++; if (iss_valid !== 1'b0) begin miscompares++; $display("FAIL flush_valid: got %b want 0", iss_valid); end
        wake_tag   = {6'd0, 6'd30};
        wake_valid = 2'b01;
        tick();
        wake_valid = 2'b00;
        vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL flush_noenq: got %0d want 0", count); end
        tick();
        vectors++; if (iss_valid !== 1'b0) begin miscompares++; $display("FAIL flush_ghost: got %b want 0", iss_valid); end
        vectors++; if (enq_ready !== 1'b1) begin miscompares++; $display("FAIL flush_ready: got %b want 1", enq_ready); end
    endtask

    task automatic test_async_reset();
        drive_enq(7'h50, 5'd17, 6'd9, 6'd0, 1'b0, 6'd0, 1'b0);
        tick();
        drive_enq(7'h51, 5'd18, 6'd10, 6'd0, 1'b0, 6'd0, 1'b0);
        tick();
        idle_enq();
        vectors++; if (iss_valid !== 1'b1 || iss_rob !== 5'd17) begin miscompares++; $display("FAIL arst_pre: got v=%b rob=%0d want v=1 rob=17", iss_valid, iss_rob); end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++; if (iss_valid !== 1'b0) begin miscompares++; $display("FAIL arst_valid: got %b want 0", iss_valid); end
        vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL arst_count: got %0d want 0", count); end
        vectors++; if (iss_rob !== 5'd0 || iss_dest !== 6'd0 || iss_op !== 7'd0) begin miscompares++; $display("FAIL arst_fields: got rob=%0d dest=%0d op=%0h want 0", iss_rob, iss_dest, iss_op); end
        #2;
        rst_n = 1'b1;
        tick();
        vectors++; if (count !== 4'd0 || iss_valid !== 1'b0) begin miscompares++; $display("FAIL arst_after: got c=%0d v=%b want c=0 v=0", count, iss_valid); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_wakeup();
        test_full();
        test_bypass();
        test_stall();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
